// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared encodings for the LSU memory controller.
// Access sizes and FSM state type.
package lsu_mem_ctrl_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

endpackage

// File: rtl/lsu_mem_ctrl_lane_align.sv
// Byte-lane steering: store enables/data, alignment check and
// right-justification of load data.
module lsu_lane_align
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  rd_addr_i,
  input  logic [1:0]  rd_size_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o,
  output logic [31:0] rdata_o
);

  logic [31:0] rd_shift;

  always_comb begin
    be_o         = 4'b1111;
    wdata_o      = wdata_i;
    misaligned_o = 1'b0;
    case (size_i)
      SIZE_BYTE: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SIZE_HALF: begin
        be_o         = 4'b0011 << addr_i;
        wdata_o      = {2{wdata_i[15:0]}};
        misaligned_o = addr_i[0];
      end
      default: misaligned_o = (addr_i != 2'b00);
    endcase
  end

  always_comb begin
    rd_shift = rdata_i >> {rd_addr_i, 3'b000};
    case (rd_size_i)
      SIZE_BYTE: rdata_o = {24'h0, rd_shift[7:0]};
      SIZE_HALF: rdata_o = {16'h0, rd_shift[15:0]};
      default:   rdata_o = rd_shift;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store memory controller: IDLE -> REQ -> DONE handshake
// with data memory, feeding the load extender.
module lsu_mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid,
  input  logic                  op_is_store,
  input  logic [ADDR_WIDTH-1:0] op_addr,
  input  logic [31:0]           op_wdata,
  input  logic [1:0]            op_size,
  input  logic                  op_sign_ext,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata,
  output logic [31:0]           load_data,
  output logic [1:0]            load_size,
  output logic                  load_sign_ext,
  output logic                  done,
  output logic                  misaligned,
  output logic                  stall
);
  import lsu_mem_ctrl_pkg::*;

  lsu_state_e            state_q;
  logic                  req_q, we_q, done_q, mis_q, sext_q, store_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            lo_q, size_q;
  logic [3:0]            be_q;
  logic [31:0]           wdata_q, ldata_q;

  logic [3:0]  be_c;
  logic [31:0] wdata_c, rdata_c;
  logic        mis_c;

  lsu_lane_align u_align (
    .addr_i       (op_addr[1:0]),
    .size_i       (op_size),
    .wdata_i      (op_wdata),
    .rd_addr_i    (lo_q),
    .rd_size_i    (size_q),
    .rdata_i      (mem_rdata),
    .be_o         (be_c),
    .wdata_o      (wdata_c),
    .misaligned_o (mis_c),
    .rdata_o      (rdata_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      sext_q  <= 1'b0;
      store_q <= 1'b0;
      addr_q  <= '0;
      lo_q    <= 2'b00;
      size_q  <= 2'b00;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      ldata_q <= 32'h0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (op_valid) begin
            lo_q    <= op_addr[1:0];
            size_q  <= op_size;
            sext_q  <= op_sign_ext;
            store_q <= op_is_store;
            if (mis_c) begin
              done_q  <= 1'b1;
              mis_q   <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              req_q   <= 1'b1;
              we_q    <= op_is_store;
              addr_q  <= {op_addr[ADDR_WIDTH-1:2], 2'b00};
              be_q    <= be_c;
              wdata_q <= wdata_c;
              state_q <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_ready) begin
            if (!store_q) ldata_q <= rdata_c;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          mis_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_req       = req_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_be        = be_q;
  assign mem_wdata     = wdata_q;
  assign load_data     = ldata_q;
  assign load_size     = size_q;
  assign load_sign_ext = sext_q;
  assign done          = done_q;
  assign misaligned    = mis_q;
  assign stall         = op_valid && !done_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, op_is_store, op_sign_ext;
  logic [31:0] op_addr, op_wdata;
  logic [1:0]  op_size;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [31:0] load_data;
  logic [1:0]  load_size;
  logic        load_sign_ext, done, misaligned, stall;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .op_valid      (op_valid),
    .op_is_store   (op_is_store),
    .op_addr       (op_addr),
    .op_wdata      (op_wdata),
    .op_size       (op_size),
    .op_sign_ext   (op_sign_ext),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .load_data     (load_data),
    .load_size     (load_size),
    .load_sign_ext (load_sign_ext),
    .done          (done),
    .misaligned    (misaligned),
    .stall         (stall)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic st, input logic [31:0] a,
                    input logic [31:0] wd, input logic [1:0] sz,
                    input logic sx);
    op_valid    = 1'b1;
    op_is_store = st;
    op_addr     = a;
    op_wdata    = wd;
    op_size     = sz;
    op_sign_ext = sx;
  endtask

  initial begin
    reset = 1'b1;
    op_valid = 0; op_is_store = 0; op_addr = 0;
    op_wdata = 0; op_size = 0; op_sign_ext = 0;
    mem_ready = 0; mem_rdata = 0;
    cyc(); cyc();
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_be", {28'h0, mem_be}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_done", {30'h0, done, misaligned}, 32'h0);
    chk("rst_ld", load_data, 32'h0);
    reset = 1'b0;
    cyc();

    // lb @0x1003
    op(1'b0, 32'h1003, 32'h0, 2'b00, 1'b0);
    cyc();
    chk("lb_req", {31'h0, mem_req}, 32'h1);
    chk("lb_we", {31'h0, mem_we}, 32'h0);
    chk("lb_addr", mem_addr, 32'h1000);
    chk("lb_be", {28'h0, mem_be}, 32'h8);
    chk("lb_stall", {31'h0, stall}, 32'h1);
    mem_ready = 1; mem_rdata = 32'hAABBCCDD;
    cyc();
    chk("lb_done", {31'h0, done}, 32'h1);
    chk("lb_nostall", {31'h0, stall}, 32'h0);
    chk("lb_reqoff", {31'h0, mem_req}, 32'h0);
    chk("lb_data", load_data, 32'h000000AA);
    chk("lb_size", {30'h0, load_size}, 32'h0);
    op_valid = 0; mem_ready = 0;
    cyc();
    chk("lb_pulse", {31'h0, done}, 32'h0);

    // sh @0x2002
    op(1'b1, 32'h2002, 32'h00001234, 2'b01, 1'b0);
    cyc();
    chk("sh_we", {31'h0, mem_we}, 32'h1);
    chk("sh_be", {28'h0, mem_be}, 32'hC);
    chk("sh_wd", mem_wdata, 32'h12341234);
    mem_ready = 1;
    cyc();
    chk("sh_done", {30'h0, done, misaligned}, 32'h2);
    chk("sh_ldkeep", load_data, 32'h000000AA);
    op_valid = 0; mem_ready = 0;
    cyc();

    // lw @0x3002 misaligned; a stray mem_ready must not matter
    op(1'b0, 32'h3002, 32'h0, 2'b10, 1'b0);
    mem_ready = 1;
    cyc();
    chk("mis_flags", {30'h0, done, misaligned}, 32'h3);
    chk("mis_noreq", {31'h0, mem_req}, 32'h0);
    op_valid = 0; mem_ready = 0;
    cyc();
    chk("mis_clear", {30'h0, done, misaligned}, 32'h0);
    chk("mis_noreq2", {31'h0, mem_req}, 32'h0);
    cyc();

    // lw @0x4000 with 3 wait cycles
    op(1'b0, 32'h4000, 32'h0, 2'b10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("wait_req", {31'h0, mem_req}, 32'h1);
      chk("wait_addr", mem_addr, 32'h4000);
      chk("wait_stall", {30'h0, stall, done}, 32'h2);
    end
    cyc();
    chk("wait_req4", {31'h0, mem_req}, 32'h1);
    mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    cyc();
    chk("wait_done", {31'h0, done}, 32'h1);
    chk("wait_data", load_data, 32'hDEADBEEF);
    op_valid = 0; mem_ready = 0;
    cyc();

    // reset during REQ, then a late mem_ready
    op(1'b0, 32'h5001, 32'h0, 2'b00, 1'b1);
    cyc();
    chk("rr_req", {31'h0, mem_req}, 32'h1);
    reset = 1; op_valid = 0;
    cyc();
    chk("rr_reqoff", {31'h0, mem_req}, 32'h0);
    chk("rr_addr", mem_addr, 32'h0);
    chk("rr_ld", load_data, 32'h0);
    chk("rr_sx", {31'h0, load_sign_ext}, 32'h0);
    reset = 0; mem_ready = 1; mem_rdata = 32'h12345678;
    cyc();
    chk("rr_nodone", {30'h0, done, mem_req}, 32'h0);
    chk("rr_ld2", load_data, 32'h0);
    mem_ready = 0;
    cyc();

    // sb @0x1 then lh @0x2 back-to-back
    op(1'b1, 32'h1, 32'h00000055, 2'b00, 1'b0);
    cyc();
    chk("sb_be", {28'h0, mem_be}, 32'h2);
    chk("sb_wd", mem_wdata, 32'h55555555);
    mem_ready = 1;
    cyc();
    chk("sb_done", {31'h0, done}, 32'h1);
    mem_ready = 0;
    op(1'b0, 32'h2, 32'h0, 2'b01, 1'b1);
    cyc();
    chk("b2b_idle", {30'h0, done, mem_req}, 32'h0);
    cyc();
    chk("lh_be", {28'h0, mem_be}, 32'hC);
    chk("lh_we", {31'h0, mem_we}, 32'h0);
    mem_ready = 1; mem_rdata = 32'h80010000;
    cyc();
    chk("lh_done", {31'h0, done}, 32'h1);
    chk("lh_data", load_data, 32'h00008001);
    chk("lh_size", {30'h0, load_size}, 32'h1);
    chk("lh_sx", {31'h0, load_sign_ext}, 32'h1);
    op_valid = 0; mem_ready = 0;
    cyc();

    // size 11 behaves as word
    op(1'b1, 32'h6000, 32'hCAFEF00D, 2'b11, 1'b0);
    cyc();
    chk("sz3_be", {28'h0, mem_be}, 32'hF);
    chk("sz3_wd", mem_wdata, 32'hCAFEF00D);
    mem_ready = 1;
    cyc();
    chk("sz3_done", {30'h0, done, misaligned}, 32'h2);
    op_valid = 0; mem_ready = 0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
